game_state_controller: RTL
==========================

GAME_STATE_CONTROLLER -- requirements
Module: game_state_controller

Interface
REQ-001 The block SHALL expose parameter DEBOUNCE_CYCLES, default 240000, meaning the number of consecutive stable cycles required to accept a button level (20 ms at 12 MHz).
REQ-002 The block SHALL expose parameter HOLD_CYCLES, default 24000000, meaning the minimum number of cycles spent in WIN or OVER before a restart is accepted (2 s).
REQ-003 The block SHALL have port clk, input, 1 bit: system clock, 12 MHz.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port button_i, input, 1 bit: raw start/jump button, asynchronous to clk, active-high.
REQ-006 The block SHALL have port score, input, 7 bits: current score from the score counter, unsigned.
REQ-007 The block SHALL have port state, output, state_t: game state from the shared package; encodings are IDLE, RUN, WIN and OVER.
REQ-008 The block SHALL have port start_pulse, output, 1 bit: one-cycle strobe on the IDLE->RUN transition.
REQ-009 The block SHALL have port btn_level, output, 1 bit: debounced button level.
REQ-010 The block SHALL have port btn_rise, output, 1 bit: one-cycle strobe on a debounced 0->1 transition.

Function
REQ-011 button_i SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Debounce counter behaviour SHALL be:
- Synchronized value differs from btn_level: counter increments.
- Counter reaches DEBOUNCE_CYCLES-1 while the difference persists: btn_level takes the new value on the next edge and the counter clears.
- Synchronized value equals btn_level: counter clears.
REQ-013 btn_rise SHALL be high for exactly the one cycle after btn_level goes 0->1; the 1->0 transition SHALL produce no strobe.
REQ-014 Latency from a stable button_i change to the btn_level change SHALL be 2 + DEBOUNCE_CYCLES cycles, ±1.
REQ-015 The FSM SHALL be one-hot or binary internally, with state registered and a single transition per cycle.
REQ-016 IDLE: on btn_rise, the next state SHALL be RUN and start_pulse SHALL assert for that same transition cycle (registered, coincident with state becoming RUN).
REQ-017 RUN: if score >= 99, the next state SHALL be WIN.
REQ-018 RUN: else if score == 0, the next state SHALL be OVER.
REQ-019 RUN: otherwise the block SHALL stay in RUN, and btn_rise SHALL be ignored for state purposes.
REQ-020 WIN/OVER: a 25-bit hold counter SHALL clear on entry and increment each cycle, saturating at HOLD_CYCLES.
REQ-021 WIN/OVER: on btn_rise with the hold counter saturated, the next state SHALL be IDLE; btn_rise before saturation SHALL be discarded, not queued.
REQ-022 The block SHALL hold WIN and OVER indefinitely with no timeout exit.
REQ-023 score values 100-127 SHALL be treated as WIN.
REQ-024 score SHALL be sampled only in RUN; in other states it SHALL be ignored.
REQ-025 An illegal or unreachable state encoding SHALL return to IDLE on the next edge.
REQ-026 start_pulse SHALL never be high for two consecutive cycles.
REQ-027 Button held high across WIN/OVER->IDLE: no new btn_rise occurs, so RUN SHALL NOT be entered until the button is released and pressed again.

Reset
REQ-028 While reset is low, the following SHALL hold asynchronously:
- state = IDLE
- start_pulse = 0, btn_level = 0, btn_rise = 0
- synchronizer flops = 0, debounce counter = 0, hold counter = 0
REQ-029 Deassertion of reset SHALL be synchronized by the system; the block SHALL operate from the first clk edge after reset goes high.
REQ-030 Reset asserted mid-RUN, WIN or OVER SHALL return state to IDLE immediately, with no strobe generated.

Verification
REQ-031 The bench SHALL use DEBOUNCE_CYCLES=4 and HOLD_CYCLES=8 for all directed scenarios below.
REQ-032 Bounce: button_i toggles every 2 cycles for 20 cycles then holds 1 -> no btn_rise during the bounce; exactly one btn_rise 6±1 cycles after the hold begins.
REQ-033 Start: state IDLE, clean press -> state RUN with start_pulse high for exactly 1 cycle; second press in RUN -> state stays RUN, no start_pulse.
REQ-034 Win/Lose: in RUN drive score 98 then 99 -> WIN on the edge after 99 appears; separate run, score 1 then 0 -> OVER; score 120 in RUN -> WIN.
REQ-035 Hold lockout: press 3 cycles after entering OVER -> remains OVER; release then press after 10 cycles -> IDLE; button held through IDLE -> stays IDLE until re-press.
REQ-036 Reset mid-game: reset low for 1 cycle while in WIN -> state IDLE, all outputs 0, hold counter 0; next press -> RUN.

Source files
------------

// File: rtl/game_state_controller.sv
// Game state controller: button synchronizer and debouncer, plus the
// IDLE/RUN/WIN/OVER game FSM with a post-game restart lockout.

package game_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WIN  = 2'd2,
        OVER = 2'd3
    } state_t;
endpackage

module game_state_controller
    import game_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 240000,
    parameter int unsigned HOLD_CYCLES     = 24000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button_i,
    input  logic [6:0] score,
    output state_t     state,
    output logic       start_pulse,
    output logic       btn_level,
    output logic       btn_rise
);

    localparam int unsigned     DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [24:0]     HOLD_MAX = 25'(HOLD_CYCLES);
    localparam logic [6:0]      WIN_SCORE = 7'd99;

    logic [1:0]      r_sync;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_btn_level;
    logic            r_btn_rise;
    state_t          r_state;
    state_t          w_next_state;
    logic            r_start_pulse;
    logic            w_start;
    logic [24:0]     r_hold_cnt;
    logic            w_sync;
    logic            w_in_end;

    assign w_sync   = r_sync[1];
    assign w_in_end = (r_state == WIN) || (r_state == OVER);

    // Two-flop synchronizer for the asynchronous button input
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[0], button_i};
        end
    end

    // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_db_cnt    <= '0;
            r_btn_level <= 1'b0;
            r_btn_rise  <= 1'b0;
        end else begin
            r_btn_rise <= 1'b0;
            if (w_sync != r_btn_level) begin
                if (r_db_cnt == DB_LAST) begin
                    r_btn_level <= w_sync;
                    r_btn_rise  <= w_sync;
                    r_db_cnt    <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    // Next-state logic; any unexpected encoding falls back to IDLE
    always_comb begin
        w_next_state = IDLE;
        case (r_state)
            IDLE: w_next_state = r_btn_rise ? RUN : IDLE;
            RUN: begin
                if (score >= WIN_SCORE) begin
                    w_next_state = WIN;
                end else if (score == '0) begin
                    w_next_state = OVER;
                end else begin
                    w_next_state = RUN;
                end
            end
            WIN, OVER: begin
                if (r_btn_rise && (r_hold_cnt == HOLD_MAX)) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = r_state;
                end
            end
            default: w_next_state = IDLE;
        endcase
        w_start = (r_state == IDLE) && (w_next_state == RUN);
    end

    // State register and start strobe, registered together so they coincide
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_start_pulse <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_start_pulse <= w_start;
        end
    end

    // Hold counter: zero outside WIN/OVER, so it is already clear on entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hold_cnt <= '0;
        end else if (!w_in_end) begin
            r_hold_cnt <= '0;
        end else if (r_hold_cnt != HOLD_MAX) begin
            r_hold_cnt <= r_hold_cnt + 25'd1;
        end
    end

    assign state       = r_state;
    assign start_pulse = r_start_pulse;
    assign btn_level   = r_btn_level;
    assign btn_rise    = r_btn_rise;

endmodule
